// File: rtl/alien_fleet_pkg.sv
// Shared types and screen constants for the invader formation block.
package alien_fleet_pkg;
  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int FLOOR_Y  = 440;

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [1:0] {S_HOLD, S_MARCH, S_DONE} state_e;
endpackage

// File: rtl/alien_fleet_edge_finder.sv
// Priority encoder over the alive bitmap: leftmost/rightmost live column, lowest live row.
module fleet_edge_finder #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0]     alive,
  output logic [$clog2(COLS)-1:0]  lc,
  output logic [$clog2(COLS)-1:0]  rc,
  output logic [$clog2(ROWS)-1:0]  lr
);
  localparam int CLW = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_any[r] = |alive[r*COLS +: COLS];
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c]) col_any[c] = 1'b1;
    end
  end

  always_comb begin
    lc = '0;
    rc = '0;
    lr = '0;
    for (int c = COLS-1; c >= 0; c--)
      if (col_any[c]) lc = CLW'(c);
    for (int c = 0; c < COLS; c++)
      if (col_any[c]) rc = CLW'(c);
    for (int r = 0; r < ROWS; r++)
      if (row_any[r]) lr = RW'(r);
  end
endmodule

// File: rtl/alien_fleet.sv
// Invader formation: march/drop timing, per-cell hit detection, win/lose flags.
module alien_fleet import alien_fleet_pkg::*; #(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int ALIEN_W  = 32,
  parameter int ALIEN_H  = 16,
  parameter int PITCH_X  = 48,
  parameter int PITCH_Y  = 32,
  parameter int STEP_X   = 4,
  parameter int DROP_Y   = 16,
  parameter int MOVE_DIV = 2500000,
  parameter int START_X  = 64,
  parameter int START_Y  = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     proj_active,
  input  logic [9:0]               proj_x,
  input  logic [9:0]               proj_y,
  output logic                     collision,
  output logic [$clog2(ROWS)-1:0]  hit_row,
  output logic [$clog2(COLS)-1:0]  hit_col,
  output logic [9:0]               fleet_x,
  output logic [9:0]               fleet_y,
  output logic [ROWS*COLS-1:0]     alive,
  output logic                     all_dead,
  output logic                     reached_floor
);
  localparam int N     = ROWS*COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int CLW   = $clog2(COLS);
  localparam int CNT_W = $clog2(MOVE_DIV+1);
  localparam int XW    = COORD_W + 1;

  state_e             state, state_nx;
  dir_e               dir;
  logic [CNT_W-1:0]   cnt;
  logic               hit_lock, drop_pend;
  logic [CLW-1:0]     lc, rc;
  logic [RW-1:0]      lr;
  logic [XW-1:0]      px, py, fx, fy;
  logic [COLS-1:0]    col_hit;
  logic [ROWS-1:0]    row_hit;
  logic               hit_any, hit_v, step, need_drop, floor_hit, dead_now;
  logic [RW-1:0]      hit_r;
  logic [CLW-1:0]     hit_c;
  logic [N-1:0]       hit_mask;
  logic [XW-1:0]      right_edge, left_edge, bottom_edge;

  fleet_edge_finder #(.ROWS(ROWS), .COLS(COLS)) u_edges (
    .alive (alive),
    .lc    (lc),
    .rc    (rc),
    .lr    (lr)
  );

  // 11-bit working copies so edge sums never wrap
  assign px = {1'b0, proj_x};
  assign py = {1'b0, proj_y};
  assign fx = {1'b0, fleet_x};
  assign fy = {1'b0, fleet_y};

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [XW-1:0] cx;
    assign cx         = fx + XW'(c*PITCH_X);
    assign col_hit[c] = (px >= cx) && (px < cx + XW'(ALIEN_W));
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [XW-1:0] ry;
    assign ry         = fy + XW'(r*PITCH_Y);
    assign row_hit[r] = (py >= ry) && (py < ry + XW'(ALIEN_H));
  end

  // Cells never overlap, so at most one term fires
  always_comb begin
    hit_any  = 1'b0;
    hit_r    = '0;
    hit_c    = '0;
    hit_mask = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_hit[r] && col_hit[c] && alive[r*COLS+c]) begin
          hit_any             = 1'b1;
          hit_r               = RW'(r);
          hit_c               = CLW'(c);
          hit_mask[r*COLS+c]  = 1'b1;
        end
  end

  assign hit_v       = hit_any && proj_active && !hit_lock && (state == S_MARCH);
  assign dead_now    = (alive == '0);
  assign step        = (state == S_MARCH) && (cnt == CNT_W'(MOVE_DIV-1)) && !dead_now;
  assign right_edge  = fx + XW'(rc) * XW'(PITCH_X) + XW'(ALIEN_W + STEP_X);
  assign left_edge   = fx + XW'(lc) * XW'(PITCH_X);
  assign need_drop   = (dir == DIR_RIGHT) ? (right_edge > XW'(SCREEN_W))
                                          : (left_edge < XW'(STEP_X));
  assign bottom_edge = fy + XW'(lr) * XW'(PITCH_Y) + XW'(ALIEN_H);
  assign floor_hit   = drop_pend && (bottom_edge >= XW'(FLOOR_Y));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_HOLD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HOLD:  if (enable)  state_nx = S_MARCH;
      S_MARCH: if (!enable) state_nx = S_HOLD;
      default: state_nx = state;
    endcase
    if (state != S_DONE && (dead_now || floor_hit)) state_nx = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alive         <= '1;
      fleet_x       <= 10'(START_X);
      fleet_y       <= 10'(START_Y);
      dir           <= DIR_RIGHT;
      cnt           <= '0;
      collision     <= 1'b0;
      hit_row       <= '0;
      hit_col       <= '0;
      hit_lock      <= 1'b0;
      drop_pend     <= 1'b0;
      all_dead      <= 1'b0;
      reached_floor <= 1'b0;
    end else begin
      collision <= 1'b0;
      drop_pend <= 1'b0;
      if (state != S_DONE) begin
        if (!proj_active) hit_lock <= 1'b0;
        if (hit_v) begin
          alive     <= alive & ~hit_mask;
          collision <= 1'b1;
          hit_row   <= hit_r;
          hit_col   <= hit_c;
          hit_lock  <= 1'b1;
        end
        if (state == S_MARCH)
          cnt <= (cnt == CNT_W'(MOVE_DIV-1)) ? '0 : cnt + 1'b1;
        // Step uses pre-hit positions; both commit on this edge
        if (step) begin
          if (need_drop) begin
            fleet_y   <= fleet_y + 10'(DROP_Y);
            dir       <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
            drop_pend <= 1'b1;
          end else if (dir == DIR_RIGHT) begin
            fleet_x <= fleet_x + 10'(STEP_X);
          end else begin
            fleet_x <= fleet_x - 10'(STEP_X);
          end
        end
        all_dead <= dead_now;
        if (floor_hit) reached_floor <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alien_fleet.sv
// Scoreboard bench for alien_fleet: stimulus pushes expected hits, a monitor pops on collision.
module tb_alien_fleet;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        proj_active = 1'b0;
  logic [9:0]  proj_x = '0, proj_y = '0;
  logic        collision;
  logic [1:0]  hit_row;
  logic [2:0]  hit_col;
  logic [9:0]  fleet_x, fleet_y;
  logic [31:0] alive;
  logic        all_dead, reached_floor;

  int errors = 0;
  int checks = 0;
  int n = 0;

  typedef struct { int r; int c; } hit_t;
  hit_t exp_q[$];

  alien_fleet #(.MOVE_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .proj_active(proj_active),
    .proj_x(proj_x), .proj_y(proj_y), .collision(collision),
    .hit_row(hit_row), .hit_col(hit_col), .fleet_x(fleet_x), .fleet_y(fleet_y),
    .alive(alive), .all_dead(all_dead), .reached_floor(reached_floor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; proj_active = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  // Enable marching; n counts edges since the fleet entered march with counter 0
  task automatic go();
    enable = 1'b1;
    tick(1);
    n = 0;
  endtask

  // Aim at the centre of cell (r,c) using the bench's own position schedule (no drops yet)
  task automatic fire(input int r, input int c);
    hit_t h;
    proj_x = 10'(64 + 4*(n/4) + c*48 + 16);
    proj_y = 10'(48 + r*32 + 8);
    proj_active = 1'b1;
    h.r = r; h.c = c;
    exp_q.push_back(h);
    tick(1);
    chk($sformatf("hit_pulse_%0d_%0d", r, c), collision, 1);
    proj_active = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (reset && collision) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_collision: row %0d col %0d, none expected", hit_row, hit_col);
      end else begin
        hit_t e;
        e = exp_q.pop_front();
        if (hit_row !== 2'(e.r) || hit_col !== 3'(e.c) || alive[e.r*8+e.c] !== 1'b0) begin
          errors++;
          $display("FAIL hit_report: got row %0d col %0d alive_bit %0d, expected row %0d col %0d alive_bit 0",
                   hit_row, hit_col, alive[e.r*8+e.c], e.r, e.c);
        end
      end
    end
  end

  initial begin
    int kd;
    bit found;

    // Reset state
    do_reset();
    chk("rst_fleet_x", fleet_x, 64);
    chk("rst_fleet_y", fleet_y, 48);
    chk("rst_alive", alive, 32'hFFFF_FFFF);
    chk("rst_flags", {collision, all_dead, reached_floor, hit_row, hit_col}, 0);

    // Hold freezes position
    tick(10);
    chk("hold_fleet_x", fleet_x, 64);

    // March and first right-edge drop
    go();
    tick(4);
    chk("march_step1", fleet_x, 68);
    tick(204);
    chk("march_52_x", fleet_x, 272);
    chk("march_52_y", fleet_y, 48);
    tick(4);
    chk("drop1_x", fleet_x, 272);
    chk("drop1_y", fleet_y, 64);
    tick(4);
    chk("left_step", fleet_x, 268);

    // Single hit, then held projectile gives no second pulse
    do_reset();
    go();
    proj_x = 10'd170; proj_y = 10'd85; proj_active = 1'b1;
    begin hit_t h; h.r = 1; h.c = 2; exp_q.push_back(h); end
    tick(1);
    chk("hit_collision", collision, 1);
    chk("hit_row", hit_row, 1);
    chk("hit_col", hit_col, 2);
    chk("hit_alive", alive, 32'hFFFF_FBFF);
    tick(1);
    chk("pulse_one_cycle", collision, 0);
    tick(2);
    chk("held_no_repeat", collision, 0);
    proj_active = 1'b0;
    tick(1);

    // Gap between column 0 and column 1
    do_reset();
    go();
    proj_x = 10'd104; proj_y = 10'd53; proj_active = 1'b1;
    tick(3);
    chk("gap_collision", collision, 0);
    chk("gap_alive", alive, 32'hFFFF_FFFF);
    proj_active = 1'b0;

    // Clear column 7: right drop now triggered by column 6 edge
    do_reset();
    go();
    for (int r = 0; r < 4; r++) fire(r, 7);
    chk("col7_alive", alive, 32'h7F7F_7F7F);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (fleet_y != 10'd48) found = 1;
    end
    chk("col7_drop_seen", found, 1);
    chk("col7_drop_x", fleet_x, 320);
    chk("col7_drop_y", fleet_y, 64);

    // Kill every alien
    do_reset();
    go();
    for (int i = 0; i < 31; i++) fire(i / 8, i % 8);
    proj_x = 10'(64 + 4*(n/4) + 7*48 + 16);
    proj_y = 10'(48 + 3*32 + 8);
    proj_active = 1'b1;
    begin hit_t h; h.r = 3; h.c = 7; exp_q.push_back(h); end
    tick(1);
    kd = n;
    chk("last_hit_alive", alive, 0);
    chk("all_dead_not_yet", all_dead, 0);
    proj_active = 1'b0;
    tick(1);
    chk("all_dead_set", all_dead, 1);
    proj_x = 10'd80; proj_y = 10'd56; proj_active = 1'b1;
    tick(20);
    chk("done_frozen_x", fleet_x, 10'(64 + 4*(kd/4)));
    chk("done_frozen_y", fleet_y, 48);
    chk("done_no_collision", collision, 0);
    chk("done_all_dead_held", all_dead, 1);
    proj_active = 1'b0;

    // Full fleet descends to the floor line
    do_reset();
    go();
    found = 0;
    for (int i = 0; i < 12000 && !found; i++) begin
      tick(1);
      if (reached_floor) found = 1;
    end
    chk("floor_reached", found, 1);
    chk("floor_y", fleet_y, 336);
    chk("floor_x", fleet_x, 0);
    chk("floor_not_dead", all_dead, 0);
    tick(20);
    chk("floor_frozen_y", fleet_y, 336);
    chk("floor_frozen_x", fleet_x, 0);

    // Reset mid-game
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("rerst_fleet_x", fleet_x, 64);
    chk("rerst_fleet_y", fleet_y, 48);
    chk("rerst_alive", alive, 32'hFFFF_FFFF);
    chk("rerst_flags", {collision, all_dead, reached_floor, hit_row, hit_col}, 0);

    tick(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alien_fleet.md
Name: alien_fleet

Overview:
- Owns the invader formation: a ROWS x COLS grid with an alive bitmap, a shared origin (fleet_x, fleet_y) and a march direction.
- Marches the grid sideways, drops it at the screen edges, and checks the live projectile position against each alien cell.
- Sits directly downstream of the projectile stage. It consumes proj_active/proj_x/proj_y and returns the collision pulse that projectile consumes.
- Its all_dead/reached_floor outputs feed the game FSM as win/lose. Its position and bitmap outputs feed the VGA renderer.

Parameters:
- ROWS, 4, alien rows
- COLS, 8, alien columns
- ALIEN_W, 32, cell width in px
- ALIEN_H, 16, cell height in px
- PITCH_X, 48, column pitch (must be > ALIEN_W)
- PITCH_Y, 32, row pitch (must be > ALIEN_H)
- STEP_X, 4, px per march step
- DROP_Y, 16, px per drop
- MOVE_DIV, 2500000, clk cycles per march tick (25 ms at 100 MHz)
- SCREEN_W, 640, right screen bound
- FLOOR_Y, 440, lose line
- START_X, 64, reset origin x
- START_Y, 48, reset origin y

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-low (0 = reset)
- enable  in  1  game in playing state
- proj_active  in  1  projectile in flight
- proj_x  in  10  projectile x (px)
- proj_y  in  10  projectile y (px)
- collision  out  1  one-cycle hit pulse to projectile
- hit_row  out  log2(ROWS)  row of last hit
- hit_col  out  log2(COLS)  column of last hit
- fleet_x  out  10  grid origin x
- fleet_y  out  10  grid origin y
- alive  out  ROWS*COLS  bit r*COLS+c = alien (r,c) alive
- all_dead  out  1  alive == 0 (win)
- reached_floor  out  1  lowest alive row touches FLOOR_Y (lose)

Behaviour:
- Reset (reset==0 at posedge) sets:
  - alive = all ones; fleet_x = START_X; fleet_y = START_Y
  - dir = RIGHT; state = S_HOLD; tick counter = 0
  - collision, hit_row, hit_col, all_dead, reached_floor, hit_lock = 0
- Reset mid-operation restores all of the above on the next edge.
- States:
  - S_HOLD: enable==0. Counter, position and hits are frozen. enable==1 goes to S_MARCH.
  - S_MARCH: counter increments each cycle. At MOVE_DIV-1 it wraps to 0 and raises an internal step. enable==0 goes to S_HOLD.
  - S_DONE: entered when all_dead or reached_floor is set. Everything is frozen and no collisions occur. Only reset exits.
- March step, using edges of the alive columns only (dead outer columns do not count):
  - dir RIGHT: if fleet_x + rc*PITCH_X + ALIEN_W + STEP_X > SCREEN_W, then drop. Otherwise fleet_x += STEP_X.
  - dir LEFT: if fleet_x + lc*PITCH_X < STEP_X, then drop. Otherwise fleet_x -= STEP_X.
  - Drop: fleet_y += DROP_Y, dir flips, x unchanged on that step.
  - lc and rc are the lowest and highest column holding any alive bit. All arithmetic is 11-bit, so there is no wrap.
- Hit check, registered with 1-cycle latency:
  - Cell (r,c) spans x in [fleet_x+c*PITCH_X, +ALIEN_W) and y in [fleet_y+r*PITCH_Y, +ALIEN_H).
  - Match requires proj_active, hit_lock==0, state S_MARCH and alive[r*COLS+c].
  - Implement as per-row/per-column comparators, no divider.
  - Cells cannot overlap, so at most one match exists.
  - On a match, the next edge clears the alive bit, pulses collision for exactly 1 cycle, latches hit_row/hit_col and sets hit_lock.
  - hit_lock clears when proj_active==0.
  - A projectile in the gap between cells produces no collision.
- Hit and march step on the same cycle: the hit is evaluated against pre-step positions, and both updates commit on that edge.
- Flags:
  - all_dead is registered. It asserts the cycle after the last alive bit clears.
  - reached_floor asserts when fleet_y + lr*PITCH_Y + ALIEN_H >= FLOOR_Y, where lr is the highest row holding any alive bit. It is evaluated after every drop.
  - If both conditions occur on the same cycle, both flags are set; the game FSM prioritises.

Decomposition:
- Shared package holds:
  - SCREEN_W, FLOOR_Y and the 10-bit coordinate width
  - the dir enum (DIR_LEFT, DIR_RIGHT)
  - the state enum (S_HOLD, S_MARCH, S_DONE)
- One sub-module, fleet_edge_finder: a combinational priority encoder taking alive and producing lc, rc, lr.

Test Plan:
- Reset, then enable=1 with MOVE_DIV=4 -> fleet_x rises by 4 every 4 cycles. After 52 steps fleet_x=272. Step 53: fleet_x=272, fleet_y=64, dir=LEFT.
- proj_active=1, proj (170,85) -> next cycle collision=1 for 1 cycle, hit_row=1, hit_col=2, alive[10]=0. Holding proj_active gives no second pulse.
- proj (104,53), in the gap between col0 and col1 -> collision stays 0, alive unchanged.
- Kill all of column 7 by hits, then march -> right drop happens when col6 right edge reaches 640: fleet_x=320, not 272.
- Kill all 32 aliens -> all_dead=1 one cycle after the last hit; state S_DONE; further steps and hits ignored.
- Let the full fleet march and drop -> reached_floor=1 after the 18th drop (fleet_y=336). Then reset=0 for one edge -> all outputs return to reset values.
